// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and miss sequencer states.
package hazard_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESUME    = 2'd2
    } miss_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register indices and status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = hazard_pkg::REG_ADDR_WIDTH_DEF
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
    logic       MemAccessM, CacheMissM, RefillDone;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       MissBusy, MissTimeoutErr;

    // Pipeline side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        output MemAccessM, CacheMissM, RefillDone,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MissBusy, MissTimeoutErr
    );

    // Hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        input  MemAccessM, CacheMissM, RefillDone,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MissBusy, MissTimeoutErr
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// One E-stage operand forwarding select; purely combinational, M stage wins over W, x0 never forwarded.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_m_i,
    input  logic                      reg_write_w_i,
    output fwd_sel_e                  sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: combinational forward/stall/flush plus dcache miss sequencer that freezes the pipe.
// HAZARD_PERF_CNT_EN adds StallCycles/MissCount performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int MISS_TIMEOUT   = 256,
    parameter int CNT_WIDTH      = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] MissCount
`endif
);

    localparam int TW = $clog2(MISS_TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_MISS_WAIT = MISS_WAIT;
    localparam logic [1:0] ST_RESUME    = RESUME;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic          miss_start;
    logic          miss_stall;
    logic          lw_stall;
    fwd_sel_e      fwd_a, fwd_b;

    fwd_sel_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_e_i       (hz.Rs1E),
        .rd_m_i       (hz.RdM),
        .rd_w_i       (hz.RdW),
        .reg_write_m_i(hz.RegWriteM),
        .reg_write_w_i(hz.RegWriteW),
        .sel_o        (fwd_a)
    );

    fwd_sel_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_e_i       (hz.Rs2E),
        .rd_m_i       (hz.RdM),
        .rd_w_i       (hz.RdW),
        .reg_write_m_i(hz.RegWriteM),
        .reg_write_w_i(hz.RegWriteW),
        .sel_o        (fwd_b)
    );

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        miss_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hz.MemAccessM && hz.CacheMissM) begin
                    state_d    = ST_MISS_WAIT;
                    tmo_cnt_d  = '0;
                    miss_start = 1'b1;
                end
            end
            ST_MISS_WAIT: begin
                // Counter saturates at the limit; the sequencer keeps waiting for the refill.
                if (tmo_cnt_q != TW'(MISS_TIMEOUT)) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_q == TW'(MISS_TIMEOUT - 1)) begin
                        err_d = 1'b1;
                    end
                end
                if (hz.RefillDone) begin
                    state_d = ST_RESUME;
                end
            end
            ST_RESUME: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign miss_stall = (state_q != ST_IDLE) || miss_start;
    assign lw_stall   = hz.ResultSrcE0 && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    assign hz.ForwardAE      = fwd_a;
    assign hz.ForwardBE      = fwd_b;
    assign hz.StallF         = miss_stall || lw_stall;
    assign hz.StallD         = miss_stall || lw_stall;
    assign hz.StallE         = miss_stall;
    assign hz.StallM         = miss_stall;
    // Frozen D/E keep their instructions, so branch and load-use flushes re-fire after release.
    assign hz.FlushD         = !miss_stall && hz.PCSrcE;
    assign hz.FlushE         = !miss_stall && (hz.PCSrcE || lw_stall);
    assign hz.FlushW         = miss_stall && (state_q != ST_RESUME);
    assign hz.MissBusy       = (state_q != ST_IDLE);
    assign hz.MissTimeoutErr = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cycles_q, miss_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (hz.StallF) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (miss_start) miss_count_q <= miss_count_q + 1'b1;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign MissCount   = miss_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 8;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        bit rwm, rww, ld, br, mem, miss, refill;
    } stim_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) ifc ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, miss_count;
`endif

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .MISS_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (ifc.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles(stall_cycles),
        .MissCount  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: an outstanding miss, a resume cycle pending, cycles spent waiting, sticky error.
    bit m_open, m_res, m_err;
    int m_wait;
    logic [14:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (s.rwm && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [14:0] dut_vec();
        return {ifc.ForwardAE, ifc.ForwardBE, ifc.StallF, ifc.StallD, ifc.StallE, ifc.StallM,
                ifc.FlushD, ifc.FlushE, ifc.FlushW, ifc.MissBusy, ifc.MissTimeoutErr};
    endfunction

    function automatic stim_t zero_stim();
        stim_t s;
        s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0; s.rde = 0; s.rdm = 0; s.rdw = 0;
        s.rwm = 0; s.rww = 0; s.ld = 0; s.br = 0; s.mem = 0; s.miss = 0; s.refill = 0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        ifc.Rs1D = s.rs1d; ifc.Rs2D = s.rs2d; ifc.Rs1E = s.rs1e; ifc.Rs2E = s.rs2e;
        ifc.RdE = s.rde; ifc.RdM = s.rdm; ifc.RdW = s.rdw;
        ifc.RegWriteM = s.rwm; ifc.RegWriteW = s.rww; ifc.ResultSrcE0 = s.ld;
        ifc.PCSrcE = s.br; ifc.MemAccessM = s.mem; ifc.CacheMissM = s.miss;
        ifc.RefillDone = s.refill;
    endtask

    // Drive one cycle, push the expected outputs, then advance the model across the coming edge.
    task automatic step(input stim_t s);
        bit idle, trig, ms, lw;
        logic [14:0] e;
        @(posedge clk);
        #1;
        apply(s);
        idle = !m_open && !m_res;
        trig = idle && s.mem && s.miss;
        ms   = !idle || trig;
        lw   = s.ld && (s.rde != 0) && ((s.rde == s.rs1d) || (s.rde == s.rs2d));
        e = {ref_fwd(s, s.rs1e), ref_fwd(s, s.rs2e), ms || lw, ms || lw, ms, ms,
             !ms && s.br, !ms && (s.br || lw), ms && !m_res, !idle, m_err};
        exp_q.push_back(e);
        if (trig) begin
            m_open = 1; m_wait = 0;
        end else if (m_open) begin
            m_wait++;
            if (m_wait >= TO) m_err = 1;
            if (s.refill) begin m_open = 0; m_res = 1; end
        end else if (m_res) begin
            m_res = 0;
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_res = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        apply(zero_stim());
        #1;
        chk("reset MissBusy", 16'(ifc.MissBusy), 16'd0);
        chk("reset MissTimeoutErr", 16'(ifc.MissTimeoutErr), 16'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs1d = 5'($urandom_range(0, 7)); s.rs2d = 5'($urandom_range(0, 7));
        s.rs1e = 5'($urandom_range(0, 7)); s.rs2e = 5'($urandom_range(0, 7));
        s.rde  = 5'($urandom_range(0, 7)); s.rdm  = 5'($urandom_range(0, 7));
        s.rdw  = 5'($urandom_range(0, 7));
        s.rwm = $urandom_range(0, 1) == 1; s.rww = $urandom_range(0, 1) == 1;
        s.ld  = $urandom_range(0, 9) < 3;  s.br  = $urandom_range(0, 9) < 2;
        s.mem = $urandom_range(0, 9) < 4;  s.miss = $urandom_range(0, 9) < 5;
        s.refill = $urandom_range(0, 9) < 2;
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("cycle outputs", 16'(dut_vec()), 16'(exp_q.pop_front()));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int busy_n, stall_n, fw_n;
        rst_n = 1'b0;
        model_reset();
        apply(zero_stim());
        #3;
        chk("por MissBusy", 16'(ifc.MissBusy), 16'd0);
        chk("por MissTimeoutErr", 16'(ifc.MissTimeoutErr), 16'd0);
        #20;
        rst_n = 1'b1;

        // Forwarding priority and x0 suppression
        s = zero_stim();
        s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1;
        step(s); #1 chk("fwdA mem", 16'(ifc.ForwardAE), 16'h2);
        s.rwm = 0;
        step(s); #1 chk("fwdA wb", 16'(ifc.ForwardAE), 16'h1);
        s.rs1e = 0; s.rdm = 0; s.rwm = 1;
        step(s); #1 chk("fwdA x0", 16'(ifc.ForwardAE), 16'h0);

        // Load-use
        s = zero_stim();
        s.ld = 1; s.rde = 7; s.rs2d = 7;
        step(s); #1 chk("lw stall", 16'({ifc.StallF, ifc.StallD, ifc.FlushE, ifc.StallE}), 16'hE);
        s.rde = 0;
        step(s); #1 chk("lw x0", 16'({ifc.StallF, ifc.FlushE}), 16'h0);

        // Branch flush
        s = zero_stim(); s.br = 1;
        step(s); #1 chk("branch flush", 16'({ifc.FlushD, ifc.FlushE, ifc.StallF}), 16'h6);
        s.br = 0;
        step(s); #1 chk("branch gone", 16'({ifc.FlushD, ifc.FlushE}), 16'h0);

        // Miss with a pending branch: flushes held off until release
        s = zero_stim(); s.mem = 1; s.miss = 1; s.br = 1;
        step(s); #1 chk("miss hides flush", 16'({ifc.FlushD, ifc.FlushE, ifc.StallM}), 16'h1);
        step(s); step(s);
        s.refill = 1; step(s);
        s.refill = 0; s.miss = 0; step(s);
        #1 chk("resume hides flush", 16'({ifc.FlushD, ifc.FlushE, ifc.FlushW}), 16'h0);
        step(s); #1 chk("flush after release", 16'({ifc.FlushD, ifc.FlushE, ifc.StallF}), 16'h6);

        // Ten-cycle refill: count busy, stall and FlushW cycles
        busy_n = 0; stall_n = 0; fw_n = 0;
        for (int c = 0; c < 14; c++) begin
            s = zero_stim();
            s.mem = (c <= 11); s.miss = (c <= 10); s.refill = (c == 10);
            step(s);
            #1;
            busy_n += int'(ifc.MissBusy);
            stall_n += int'(ifc.StallF && ifc.StallD && ifc.StallE && ifc.StallM);
            fw_n += int'(ifc.FlushW);
        end
        chk("miss busy cycles", 16'(busy_n), 16'd11);
        chk("miss stall cycles", 16'(stall_n), 16'd12);
        chk("miss flushW cycles", 16'(fw_n), 16'd11);
        chk("long wait err", 16'(ifc.MissTimeoutErr), 16'd1);
        reset_mid_cycle();

        // Timeout without refill, then reset mid-wait
        s = zero_stim(); s.mem = 1; s.miss = 1;
        for (int c = 0; c < 8; c++) step(s);
        step(s); #1 chk("err before limit", 16'(ifc.MissTimeoutErr), 16'd0);
        step(s); #1 chk("err at limit", 16'(ifc.MissTimeoutErr), 16'd1);
        step(s);
        reset_mid_cycle();

        for (int c = 0; c < 600; c++) step(rand_stim());

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
